mux_rr_stream: RTL and testbench

Parametrised N-way, DATA_W-bit stream multiplexer with valid/ready handshakes and a registered output stage. It generalises the fixed 8:1 32-bit select mux into a flow-controlled block with two modes: an externally selected channel, or round-robin arbitration among requesting inputs. It sits between producers such as the LSU, fetch and debug ports and a single shared consumer, such as a bus master port or writeback queue.

---
 rtl/mux_rr_stream.sv | 125 ++++++++++++
 tb/tb_mux_rr_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_stream
// Purpose  : N-way, DATA_W-bit stream multiplexer with valid/ready handshakes
//            and a registered output stage. MODE=0 forwards the channel named
//            by sel; MODE=1 arbitrates round-robin among requesting inputs.
// Ports    : clk       - sole clock, rising edge
//            rst_n     - synchronous active-low reset
//            in_valid  - per-channel valid (bit i = channel i)
//            in_data   - flattened data, channel i at [i*DATA_W +: DATA_W]
//            in_ready  - per-channel ready (combinational, one-hot or zero)
//            sel       - channel select, used only when MODE=0
//            out_valid - registered output valid
//            out_data  - registered output data
//            out_src   - index of the channel that supplied out_data
//            out_ready - consumer ready
// Params   : NUM_IN (2..16), DATA_W, SEL_W = $clog2(NUM_IN), MODE (0/1)
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_stream #(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 32,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
);

  logic              load;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic              xfer;

  // Output register can take a beat when empty or draining this cycle.
  assign load = !out_valid || out_ready;

  // grant_vld already implies in_valid[grant_idx], so a granted, loadable
  // cycle is exactly a transfer. Reset suppresses all handshakes.
  assign xfer = rst_n && load && grant_vld;

  generate
    if (MODE == 0) begin : g_ext_sel
      // Out-of-range sel values never match a channel, so nothing is granted.
      always_comb begin
        grant_idx = sel;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel == SEL_W'(i)) grant_vld = in_valid[i];
        end
      end
    end else begin : g_rr
      logic [SEL_W-1:0] ptr;
      logic             unused_sel;

      assign unused_sel = ^sel;

      // Walk the search order from the far end back to ptr so the entry
      // closest to ptr (highest priority) is the last one written.
      always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_vld = |in_valid;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
          idx = int'(ptr) + k;
          if (idx >= NUM_IN) idx = idx - NUM_IN;
          if (in_valid[idx]) grant_idx = SEL_W'(idx);
        end
      end

      // Priority moves to the channel after the winner, wrapping at NUM_IN-1.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (xfer) begin
          if (grant_idx == SEL_W'(NUM_IN - 1)) ptr <= '0;
          else                                 ptr <= grant_idx + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  // On load without a transfer only valid drops; data/src keep the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_stream
// Purpose  : Self-checking bench for mux_rr_stream. Drives one MODE=0 and one
//            MODE=1 instance from shared stimulus; expected beats are queued
//            when stimulus is applied and popped when the output loads.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_stream;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int SW = 3;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [SW-1:0]   sel;
  logic            out_ready;

  logic [N-1:0]    rdy0, rdy1;
  logic            ov0, ov1;
  logic [DW-1:0]   od0, od1;
  logic [SW-1:0]   os0, os1;

  int    checks = 0;
  int    passed = 0;
  beat_t sb[$];
  beat_t exp_b;

  always #5 clk = ~clk;

  mux_rr_stream #(.NUM_IN(N), .DATA_W(DW), .SEL_W(SW), .MODE(0)) dut_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .sel(sel), .out_valid(ov0), .out_data(od0),
    .out_src(os0), .out_ready(out_ready)
  );

  mux_rr_stream #(.NUM_IN(N), .DATA_W(DW), .SEL_W(SW), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .sel(sel), .out_valid(ov1), .out_data(od1),
    .out_src(os1), .out_ready(out_ready)
  );

  function automatic beat_t mk(input int s);
    return {SW'(s), 32'hA000_0000 + 32'(s)};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; sel = '0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; sel = 3'd5;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({ov0, od0, os0, rdy0} !== '0) $display("FAIL reset_sel: got v=%b d=%h s=%0d r=%h want all 0", ov0, od0, os0, rdy0);
      else passed++;
      checks++;
      if ({ov1, od1, os1, rdy1} !== '0) $display("FAIL reset_rr: got v=%b d=%h s=%0d r=%h want all 0", ov1, od1, os1, rdy1);
      else passed++;
    end
    rst_n = 1'b1; #1;
    checks++;
    if (rdy1 !== 8'h01) $display("FAIL reset_rr_first_ready: got %h want 01", rdy1);
    else passed++;
    checks++;
    if (rdy0 !== 8'h20) $display("FAIL reset_sel_first_ready: got %h want 20", rdy0);
    else passed++;
    sb.push_back(mk(0));
    @(posedge clk); #1;
    exp_b = sb.pop_front();
    checks++;
    if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL reset_rr_first_beat: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", ov1, os1, od1, exp_b.src, exp_b.data);
    else passed++;
  endtask

  task automatic test_mode0_select;
    int sels[4] = '{0, 7, 2, 5};
    do_reset();
    in_valid = '1;
    foreach (sels[j]) begin
      sel = SW'(sels[j]); #1;
      checks++;
      if (rdy0 !== (8'h01 << sels[j])) $display("FAIL sel_ready[%0d]: got %h want %h", sels[j], rdy0, 8'h01 << sels[j]);
      else passed++;
      sb.push_back(mk(sels[j]));
      @(posedge clk); #1;
      exp_b = sb.pop_front();
      checks++;
      if ({ov0, os0, od0} !== {1'b1, exp_b}) $display("FAIL sel_beat[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", sels[j], ov0, os0, od0, exp_b.src, exp_b.data);
      else passed++;
    end
    sel = 3'd5; in_valid = 8'hDF; #1;
    checks++;
    if (rdy0 !== 8'h00) $display("FAIL sel_invalid_ready: got %h want 00", rdy0);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({ov0, os0, od0} !== {1'b0, mk(5)}) $display("FAIL sel_invalid_out: got v=%b s=%0d d=%h want v=0 s=5 d=a0000005", ov0, os0, od0);
    else passed++;
  endtask

  task automatic test_rr_fairness;
    do_reset();
    in_valid = '1;
    for (int c = 0; c < 16; c++) begin
      sb.push_back(mk(c % N));
      @(posedge clk); #1;
      exp_b = sb.pop_front();
      checks++;
      if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL fair[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", c, ov1, os1, od1, exp_b.src, exp_b.data);
      else passed++;
    end
  endtask

  task automatic test_rr_sparse_wrap;
    int seq[8] = '{1, 7, 1, 7, 1, 2, 2, 2};
    do_reset();
    foreach (seq[j]) begin
      in_valid = (j < 5) ? 8'h82 : 8'h04; #1;
      checks++;
      if (rdy1 !== (8'h01 << seq[j])) $display("FAIL sparse_ready[%0d]: got %h want %h", j, rdy1, 8'h01 << seq[j]);
      else passed++;
      sb.push_back(mk(seq[j]));
      @(posedge clk); #1;
      exp_b = sb.pop_front();
      checks++;
      if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL sparse_beat[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", j, ov1, os1, od1, exp_b.src, exp_b.data);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] pats[4] = '{8'hFF, 8'h00, 8'h55, 8'hAA};
    do_reset();
    in_valid = 8'h08;
    sb.push_back(mk(3));
    @(posedge clk); #1;
    exp_b = sb.pop_front();
    checks++;
    if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL bp_first: got v=%b s=%0d d=%h want v=1 s=3", ov1, os1, od1);
    else passed++;
    out_ready = 1'b0;
    foreach (pats[j]) begin
      in_valid = pats[j]; #1;
      checks++;
      if (rdy1 !== 8'h00) $display("FAIL bp_ready[%0d]: got %h want 00", j, rdy1);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if ({ov1, os1, od1} !== {1'b1, mk(3)}) $display("FAIL bp_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=3 d=a0000003", j, ov1, os1, od1);
      else passed++;
    end
    out_ready = 1'b1; in_valid = '1; #1;
    checks++;
    if (rdy1 !== 8'h10) $display("FAIL bp_resume_ready: got %h want 10", rdy1);
    else passed++;
    sb.push_back(mk(4));
    sb.push_back(mk(5));
    repeat (2) begin
      @(posedge clk); #1;
      exp_b = sb.pop_front();
      checks++;
      if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL bp_resume_beat: got v=%b s=%0d d=%h want v=1 s=%0d d=%h", ov1, os1, od1, exp_b.src, exp_b.data);
      else passed++;
    end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    in_valid = 8'h40;
    sb.push_back(mk(6));
    @(posedge clk); #1;
    exp_b = sb.pop_front();
    checks++;
    if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL mid_pre: got v=%b s=%0d d=%h want v=1 s=6", ov1, os1, od1);
    else passed++;
    rst_n = 1'b0; in_valid = '1; out_ready = 1'b0; #1;
    checks++;
    if (rdy1 !== 8'h00) $display("FAIL mid_ready_in_reset: got %h want 00", rdy1);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({ov1, os1, od1} !== '0) $display("FAIL mid_cleared: got v=%b s=%0d d=%h want all 0", ov1, os1, od1);
    else passed++;
    rst_n = 1'b1; out_ready = 1'b1; #1;
    checks++;
    if (rdy1 !== 8'h01) $display("FAIL mid_restart_ready: got %h want 01", rdy1);
    else passed++;
    sb.push_back(mk(0));
    @(posedge clk); #1;
    exp_b = sb.pop_front();
    checks++;
    if ({ov1, os1, od1} !== {1'b1, exp_b}) $display("FAIL mid_restart_beat: got v=%b s=%0d d=%h want v=1 s=0", ov1, os1, od1);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; sel = '0;
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_mode0_select();
    test_rr_fairness();
    test_rr_sparse_wrap();
    test_backpressure();
    test_reset_midstream();
    checks++;
    if (sb.size() !== 0) $display("FAIL sb_drained: got %0d entries want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
